seq_divider: RTL and testbench
==============================

# seq_divider

Iterative radix-2 restoring unsigned divider: the inverse companion to the Dadda multiplier datapath. It accepts one dividend/divisor pair per transaction over a valid/ready handshake and produces quotient and remainder after W iteration cycles. Each iteration's trial subtraction is done by a parallel-prefix (Kogge-Stone) subtractor built from the shared PG/black-cell primitives. Results return over a second valid/ready handshake.

## Interface
- W, default 8: operand width. Legal range is 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. It is synchronous and active-high.
- in_valid  in  1  the operand pair is valid.
- in_ready  out  1  the block can accept operands. High only in IDLE.
- dividend  in  W  numerator, unsigned.
- divisor  in  W  denominator, unsigned.
- out_valid  out  1  the result is valid. High only in DONE.
- out_ready  in  1  the consumer takes the result.
- quotient  out  W  dividend / divisor.
- remainder  out  W  dividend mod divisor.
- div_by_zero  out  1  set when the accepted divisor was 0.

## Operation
- States are IDLE, BUSY and DONE, in a 2-bit encoding.
- **IDLE:**
  - If in_valid is high (so in_valid & in_ready), capture the operands into the working registers: Q = dividend, D = divisor, R = 0 (W+1 bits), cnt = 0.
  - If divisor == 0, go to DONE with quotient = all-ones, remainder = dividend, div_by_zero = 1.
  - Otherwise go to BUSY.
- **BUSY:** each edge performs one iteration.
  - Shift: R' = {R[W-1:0], Q[W-1]}.
  - Trial subtraction: T = R' − {0, D}, W+1 bits, with borrow out.
  - If there is no borrow: R = T and Q = {Q[W-2:0], 1}.
  - If there is a borrow: R = R' and Q = {Q[W-2:0], 0}.
  - cnt increments each iteration. At cnt == W−1 the iteration completes and the state goes to DONE.
  - On entering DONE, quotient = Q and remainder = R[W-1:0] are registered, and div_by_zero = 0.
- **DONE:**
  - out_valid is high.
  - quotient, remainder and div_by_zero hold stable while out_ready is low.
  - When out_ready is high, go to IDLE on that edge.
- Output registers keep their last values in IDLE. Only out_valid qualifies them.
- The invariant R < D holds after every iteration, so R always fits in W+1 bits.
- in_valid is ignored outside IDLE. Operands are not buffered.

## Timing
- **Reset values** (applied at the first rising edge with rst high):
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, cnt = 0.
- **Latency:**
  - Normal case: out_valid rises exactly W+1 edges after the accepting edge (1 capture edge, then W iterations).
  - Divide by zero: out_valid rises 1 edge after the accepting edge.
- **Throughput:** at most one result every W+2 cycles, because IDLE is revisited between transactions.
- **in_ready and out_valid** are decoded combinationally from the state register. Neither depends combinationally on in_valid or out_ready.
- **out_ready already high when DONE is entered:** the result is consumed on the first DONE cycle, and the next IDLE cycle follows.
- **Reset mid-BUSY or mid-DONE:** the transaction is abandoned. The next state is IDLE, and out_valid never asserts for that transaction.
- **Reset and handshake on the same edge:** reset wins.

## Structure
- **Sub-module `ks_subtractor #(N)`:**
  - Computes A + ~B + 1.
  - Uses PG generation and log2(N) black-cell prefix layers, with carry-in 1 folded into the bit-0 generate.
  - Outputs diff[N-1:0] and borrow = ~carry_out.
  - Instantiated once with N = W+1.
- **Shared package `div_pkg`:**
  - state typedef (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2).
  - Constant CNT_W = $clog2(W) for the iteration counter.
- **Sequential logic:**
  - One always block holds the state, counter and working registers.
  - Next-state logic is combinational.

## Test plan
- W = 8, 200 / 7 → after 9 edges: out_valid = 1, quotient = 28, remainder = 4, div_by_zero = 0.
- 5 / 9 → quotient = 0, remainder = 5. Then 255 / 1 → quotient = 255, remainder = 0. Then 255 / 255 → quotient = 1, remainder = 0.
- 77 / 0 → after 1 edge: quotient = 255, remainder = 77, div_by_zero = 1. in_ready stays low until out_ready is pulsed.
- 100 / 3 with out_ready held low for 5 cycles → quotient = 33 and remainder = 1 are held stable. in_ready stays 0 throughout. The result is released on the out_ready edge.
- Accept 200 / 7, assert rst during iteration 4 → next cycle state = IDLE, in_ready = 1, out_valid never rises. A following 9 / 2 returns quotient = 4, remainder = 1.
- Randomized back-to-back operands, including W = 16, with out_ready toggling → every result matches a reference model, and every accepted transaction yields exactly one output.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  // Controller states; the 2-bit encoding is visible in the state register.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter for a W-bit divider (counts 0..W-1).
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ks_subtractor.sv
// Kogge-Stone parallel-prefix subtractor: diff = a + ~b + 1, borrow = ~carry_out.
// The carry-in of 1 is folded into the bit-0 generate term, so the prefix tree
// needs no separate carry-in input.
module ks_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int L = $clog2(N);

  logic [N-1:0] w_bn;
  logic [N-1:0] w_p0;
  logic [N-1:0] w_g0;
  logic [N-1:0] w_g_fin;
  logic [N-1:0] w_carry;

  assign w_bn = ~b;
  assign w_p0 = a ^ w_bn;
  // Bit 0 generates whenever a0 | ~b0 because the implicit carry-in is 1.
  assign w_g0 = {a[N-1:1] & w_bn[N-1:1], a[0] | w_bn[0]};

  // Group-generate per prefix level (black cells on the generate side).
  for (genvar k = 0; k <= L; k++) begin : g_gl
    logic [N-1:0] w_g;
    if (k == 0) begin : g_base
      assign w_g = w_g0;
    end else begin : g_cell
      localparam int DIST = 1 << (k - 1);
      assign w_g = g_gl[k-1].w_g | (g_pl[k-1].w_p & (g_gl[k-1].w_g << DIST));
    end
  end

  // Group-propagate per prefix level; the last level's propagate is never needed.
  for (genvar k = 0; k < L; k++) begin : g_pl
    logic [N-1:0] w_p;
    if (k == 0) begin : g_base
      assign w_p = w_p0;
    end else begin : g_cell
      localparam int DIST = 1 << (k - 1);
      localparam logic [N-1:0] MASK = {N{1'b1}} >> (N - DIST);
      assign w_p = g_pl[k-1].w_p & ((g_pl[k-1].w_p << DIST) | MASK);
    end
  end

  assign w_g_fin = g_gl[L].w_g;
  // Carry into bit i is the group generate of bits i-1..0; bit 0 sees the carry-in.
  assign w_carry = {w_g_fin[N-2:0], 1'b1};
  assign diff    = w_p0 ^ w_carry;
  assign borrow  = ~w_g_fin[N-1];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider with valid/ready on both sides.
// One quotient bit is resolved per BUSY cycle using a prefix-tree subtractor.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = cnt_width(W);

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [W-1:0]     r_q,      w_q_nxt;
  logic [W-1:0]     r_d,      w_d_nxt;
  logic [W:0]       r_rem,    w_rem_nxt;
  logic [W-1:0]     r_quot,   w_quot_nxt;
  logic [W-1:0]     r_remo,   w_remo_nxt;
  logic             r_dbz,    w_dbz_nxt;

  logic [W:0]       w_shift;
  logic [W:0]       w_diff;
  logic             w_borrow;
  logic [W-1:0]     w_q_iter;
  logic [W:0]       w_rem_iter;

  // Shift the next dividend bit into the partial remainder, then trial-subtract D.
  assign w_shift = {r_rem[W-1:0], r_q[W-1]};

  ks_subtractor #(.N(W + 1)) u_sub (
    .a      (w_shift),
    .b      ({1'b0, r_d}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  assign w_q_iter   = {r_q[W-2:0], ~w_borrow};
  assign w_rem_iter = w_borrow ? w_shift : w_diff;

  // Next-state and datapath update for the IDLE/BUSY/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_d_nxt     = r_d;
    w_rem_nxt   = r_rem;
    w_quot_nxt  = r_quot;
    w_remo_nxt  = r_remo;
    w_dbz_nxt   = r_dbz;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_q_nxt   = dividend;
          w_d_nxt   = divisor;
          w_rem_nxt = {(W + 1){1'b0}};
          w_cnt_nxt = {CNT_W{1'b0}};
          if (divisor == {W{1'b0}}) begin
            // Division by zero short-circuits straight to the result.
            w_state_nxt = DONE;
            w_quot_nxt  = {W{1'b1}};
            w_remo_nxt  = dividend;
            w_dbz_nxt   = 1'b1;
          end else begin
            w_state_nxt = BUSY;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        w_q_nxt   = w_q_iter;
        w_rem_nxt = w_rem_iter;
        w_cnt_nxt = r_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
        if (r_cnt == CNT_W'(W - 1)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_quot_nxt  = w_q_iter;
          w_remo_nxt  = w_rem_iter[W-1:0];
          w_dbz_nxt   = 1'b0;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Register state, counter, working registers and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_q     <= {W{1'b0}};
      r_d     <= {W{1'b0}};
      r_rem   <= {(W + 1){1'b0}};
      r_quot  <= {W{1'b0}};
      r_remo  <= {W{1'b0}};
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_d     <= w_d_nxt;
      r_rem   <= w_rem_nxt;
      r_quot  <= w_quot_nxt;
      r_remo  <= w_remo_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at W=8 (directed + random) and W=16 (random).
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  dividend8 = '0, divisor8 = '0;
  logic        in_ready8, out_valid8, dbz8;
  logic [7:0]  quot8, rem8;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] dividend16 = '0, divisor16 = '0;
  logic        in_ready16, out_valid16, dbz16;
  logic [15:0] quot16, rem16;

  int   errors = 0;
  int   checks = 0;
  exp_t sb8[$];
  exp_t sb16[$];
  int   pushes8 = 0, pops8 = 0, pushes16 = 0, pops16 = 0;
  bit   rand_done = 1'b0;

  always #5 clk = ~clk;

  seq_divider #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8),
    .out_ready(out_ready8), .quotient(quot8), .remainder(rem8),
    .div_by_zero(dbz8)
  );

  seq_divider #(.W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .dividend(dividend16), .divisor(divisor16), .out_valid(out_valid16),
    .out_ready(out_ready16), .quotient(quot16), .remainder(rem16),
    .div_by_zero(dbz16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division; divide-by-zero yields all-ones / dividend.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (b == 32'd0) begin
      e.q = mask; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  // Offer one operand pair, wait (bounded) for acceptance, record expectation.
  task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n;
    bit rdy;
    if (sel == 0) begin
      in_valid8 = 1'b1; dividend8 = a[7:0]; divisor8 = b[7:0];
    end else begin
      in_valid16 = 1'b1; dividend16 = a[15:0]; divisor16 = b[15:0];
    end
    n = 0;
    @(negedge clk);
    rdy = (sel == 0) ? in_ready8 : in_ready16;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? in_ready8 : in_ready16;
    end
    if (!rdy) chk("accept_timeout", 32'(n), 32'd0);
    if (push) begin
      if (sel == 0) begin
        sb8.push_back(model(8, a, b)); pushes8++;
      end else begin
        sb16.push_back(model(16, a, b)); pushes16++;
      end
    end
    @(posedge clk);
    #1;
    if (sel == 0) in_valid8 = 1'b0; else in_valid16 = 1'b0;
  endtask

  // After the accepting edge, count edges until out_valid (edge count includes accept).
  task automatic wait_valid8(input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid8 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic release8();
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
  endtask

  // Monitor for W=8: a result is consumed when out_valid & out_ready at an edge.
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) begin
        chk("unexpected_out8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        pops8++;
        chk("quot8", 32'(quot8), e.q);
        chk("rem8", 32'(rem8), e.r);
        chk("dbz8", 32'(dbz8), 32'(e.z));
      end
    end
  end

  // Monitor for W=16.
  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready16) begin
      if (sb16.size() == 0) begin
        chk("unexpected_out16", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb16.pop_front();
        pops16++;
        chk("quot16", 32'(quot16), e.q);
        chk("rem16", 32'(rem16), e.r);
        chk("dbz16", 32'(dbz16), 32'(e.z));
      end
    end
  end

  task automatic rand_drive(input int sel, input int w, input int n);
    logic [31:0] a, b, mask;
    mask = (32'd1 << w) - 32'd1;
    for (int i = 0; i < n; i++) begin
      a = $urandom() & mask;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = mask;
        3: b = $urandom_range(1, 15);
        default: b = $urandom() & mask;
      endcase
      if ($urandom_range(0, 9) == 0) a = mask;
      send(sel, a, b, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    bit   seen;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_quot", 32'(quot8), 32'd0);
    chk("rst_rem", 32'(rem8), 32'd0);
    chk("rst_dbz", 32'(dbz8), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 200 / 7 with latency W+1.
    send(0, 32'd200, 32'd7, 1'b1);
    wait_valid8(9);
    release8();

    // Boundary operand pairs.
    send(0, 32'd5, 32'd9, 1'b1);   wait_valid8(9); release8();
    send(0, 32'd255, 32'd1, 1'b1); wait_valid8(9); release8();
    send(0, 32'd255, 32'd255, 1'b1); wait_valid8(9); release8();

    // Divide by zero: one-edge latency, in_ready low until released.
    send(0, 32'd77, 32'd0, 1'b1);
    wait_valid8(1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("dbz_in_ready_low", 32'(in_ready8), 32'd0);
    end
    release8();

    // Result held stable while out_ready is low.
    send(0, 32'd100, 32'd3, 1'b1);
    wait_valid8(9);
    e = model(8, 32'd100, 32'd3);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_quot", 32'(quot8), e.q);
      chk("hold_rem", 32'(rem8), e.r);
      chk("hold_valid", 32'(out_valid8), 32'd1);
      chk("hold_in_ready", 32'(in_ready8), 32'd0);
    end
    release8();
    chk("release_in_ready", 32'(in_ready8), 32'd1);

    // Reset during iteration 4 abandons the transaction.
    send(0, 32'd200, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready8), 32'd1);
    chk("abort_out_valid", 32'(out_valid8), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid8) seen = 1'b1;
    end
    chk("abort_never_valid", 32'(seen), 32'd0);
    send(0, 32'd9, 32'd2, 1'b1);
    wait_valid8(9);
    release8();

    // Randomized traffic on both widths with toggling out_ready.
    fork
      begin
        fork
          rand_drive(0, 8, 120);
          rand_drive(1, 16, 80);
        join
        for (int i = 0; i < 2000 && (sb8.size() != 0 || sb16.size() != 0); i++) begin
          @(posedge clk);
        end
        repeat (4) @(posedge clk);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready8 = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready8 = 1'b0;
      end
      begin
        while (!rand_done) begin
          out_ready16 = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready16 = 1'b0;
      end
    join

    chk("count8", 32'(pops8), 32'(pushes8));
    chk("count16", 32'(pops16), 32'(pushes16));
    chk("drain8", 32'(sb8.size()), 32'd0);
    chk("drain16", 32'(sb16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
